// File: rtl/filter_pump_ctrl.sv
// filter_pump_ctrl
//   Two-pump filter sequencer. Pump A fills the filter stage, pump B drains it.
//   A criticality vector (gated by enable) starts a fill/drain cycle; an empty
//   sensor ends each drain. Duty words ramp up softly on a shared prescaler
//   tick and drop at once when lowered. A drain watchdog latches FAULT until
//   fault_clear is pulsed.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   status_data  in   per-source criticality flags, any bit set = critical
//   is_empty     in   filter stage empty (synchronous to clk)
//   enable       in   global run enable
//   fault_clear  in   single-cycle pulse, leaves FAULT
//   pwm_duty_a   out  fill pump duty (registered)
//   pwm_duty_b   out  drain pump duty (registered)
//   state_o      out  current state: STOP=0 FILLING=1 DRAINING_MIN=2
//                     DRAINING_MAX=3 STOPPING=4 FAULT=5
//   fault        out  high while in FAULT
module filter_pump_ctrl #(
    parameter int unsigned     STATUS_W             = 4,
    parameter int unsigned     PWM_W                = 8,
    parameter int unsigned     PWM_MAX              = 230,
    parameter int unsigned     PWM_MIN              = 77,
    parameter int unsigned     TIMER_W              = 33,
    parameter longint unsigned FILL_CYCLES          = 64'd6_000_000_000,
    parameter longint unsigned MIN_CYCLES           = 64'd250_000_000,
    parameter longint unsigned DRAIN_TIMEOUT_CYCLES = 64'd1_500_000_000,
    parameter int unsigned     RAMP_DIV             = 50_000,
    parameter int unsigned     RAMP_STEP            = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [STATUS_W-1:0] status_data,
    input  logic                is_empty,
    input  logic                enable,
    input  logic                fault_clear,
    output logic [PWM_W-1:0]    pwm_duty_a,
    output logic [PWM_W-1:0]    pwm_duty_b,
    output logic [2:0]          state_o,
    output logic                fault
);

    typedef enum logic [2:0] {
        ST_STOP      = 3'd0,
        ST_FILLING   = 3'd1,
        ST_DRAIN_MIN = 3'd2,
        ST_DRAIN_MAX = 3'd3,
        ST_STOPPING  = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    localparam logic [TIMER_W-1:0] FILL_LIM = TIMER_W'(FILL_CYCLES);
    localparam logic [TIMER_W-1:0] MIN_LIM  = TIMER_W'(MIN_CYCLES);
    localparam logic [TIMER_W-1:0] WD_LIM   = TIMER_W'(DRAIN_TIMEOUT_CYCLES);

    localparam logic [PWM_W-1:0] DUTY_MAX = PWM_W'(PWM_MAX);
    localparam logic [PWM_W-1:0] DUTY_MIN = PWM_W'(PWM_MIN);
    localparam logic [PWM_W:0]   STEP_EXT = (PWM_W + 1)'(RAMP_STEP);

    localparam int unsigned      PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  fill_q, fill_d;
    logic [TIMER_W-1:0]  min_q, min_d;
    logic [TIMER_W-1:0]  wd_q, wd_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_W-1:0]    duty_a_q, duty_a_d;
    logic [PWM_W-1:0]    duty_b_q, duty_b_d;

    logic                crit;
    logic                fill_exp, min_exp, wd_exp;
    logic                in_drain;
    logic                tick;
    logic [PWM_W-1:0]    tgt_a, tgt_b;

    assign crit     = (|status_data) & enable;
    assign fill_exp = (fill_q >= FILL_LIM);
    assign min_exp  = (min_q >= MIN_LIM);
    assign wd_exp   = (wd_q >= WD_LIM);
    assign in_drain = (state_q == ST_DRAIN_MIN) || (state_q == ST_DRAIN_MAX) ||
                      (state_q == ST_STOPPING);
    assign tick     = (pre_q == PRE_LAST);

    function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] t);
        sat_inc = (t == '1) ? t : t + 1'b1;
    endfunction

    // Raise by one step per tick (clamped at target), lower or zero at once.
    function automatic logic [PWM_W-1:0] ramp_next(input logic [PWM_W-1:0] duty,
                                                   input logic [PWM_W-1:0] target,
                                                   input logic             tk);
        logic [PWM_W:0] sum;
        sum       = {1'b0, duty} + STEP_EXT;
        ramp_next = duty;
        if (target == '0) begin
            ramp_next = '0;
        end else if (target < duty) begin
            ramp_next = target;
        end else if ((target > duty) && tk) begin
            ramp_next = (sum > {1'b0, target}) ? target : sum[PWM_W-1:0];
        end
    endfunction

    // Next-state logic; case order encodes transition priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (crit) state_d = ST_FILLING;
            end
            ST_FILLING: begin
                if (!crit)         state_d = ST_STOPPING;
                else if (fill_exp) state_d = ST_DRAIN_MIN;
            end
            ST_DRAIN_MIN: begin
                if (wd_exp)        state_d = ST_FAULT;
                else if (!crit)    state_d = ST_STOPPING;
                else if (min_exp)  state_d = ST_DRAIN_MAX;
                else if (is_empty) state_d = ST_FILLING;
            end
            ST_DRAIN_MAX: begin
                if (wd_exp)        state_d = ST_FAULT;
                else if (!crit)    state_d = ST_STOPPING;
                else if (is_empty) state_d = ST_FILLING;
            end
            ST_STOPPING: begin
                if (wd_exp)        state_d = ST_FAULT;
                else if (is_empty) state_d = ST_STOP;
            end
            ST_FAULT: begin
                if (fault_clear) state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Timers and prescaler. The watchdog spans all three drain states and
    // restarts whenever the stage reports empty.
    always_comb begin
        fill_d = '0;
        min_d  = '0;
        wd_d   = '0;
        pre_d  = tick ? '0 : pre_q + 1'b1;
        if (state_q == ST_FILLING)   fill_d = sat_inc(fill_q);
        if (state_q == ST_DRAIN_MIN) min_d  = sat_inc(min_q);
        if (in_drain && !is_empty)   wd_d   = sat_inc(wd_q);
    end

    // Duty targets from the registered state.
    always_comb begin
        tgt_a = '0;
        tgt_b = '0;
        case (state_q)
            ST_FILLING:   tgt_a = DUTY_MAX;
            ST_DRAIN_MIN: tgt_b = DUTY_MIN;
            ST_DRAIN_MAX: tgt_b = DUTY_MAX;
            ST_STOPPING:  tgt_b = DUTY_MAX;
            default: begin
                tgt_a = '0;
                tgt_b = '0;
            end
        endcase
        duty_a_d = ramp_next(duty_a_q, tgt_a, tick);
        duty_b_d = ramp_next(duty_b_q, tgt_b, tick);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_STOP;
            fill_q   <= '0;
            min_q    <= '0;
            wd_q     <= '0;
            pre_q    <= '0;
            duty_a_q <= '0;
            duty_b_q <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            min_q    <= min_d;
            wd_q     <= wd_d;
            pre_q    <= pre_d;
            duty_a_q <= duty_a_d;
            duty_b_q <= duty_b_d;
        end
    end

    assign pwm_duty_a = duty_a_q;
    assign pwm_duty_b = duty_b_q;
    assign state_o    = state_q;
    assign fault      = (state_q == ST_FAULT);

endmodule
